// File: rtl/sdram_arbiter_if.sv
// Request/grant bundle between the FIFO control logic, the SDRAM command
// unit and the arbiter. The arbiter takes the slave side.
interface sdram_arbiter_if;
    logic       init_done;
    logic       wr_req;
    logic       rd_req;
    logic       rd_valid;
    logic       cmd_done;
    logic       cmd_start;
    logic [1:0] cmd_type;
    logic       wr_ack;
    logic       rd_ack;
    logic       busy;
    logic       ref_err;

    modport master (
        output init_done, wr_req, rd_req, rd_valid, cmd_done,
        input  cmd_start, cmd_type, wr_ack, rd_ack, busy, ref_err
    );

    modport slave (
        input  init_done, wr_req, rd_req, rd_valid, cmd_done,
        output cmd_start, cmd_type, wr_ack, rd_ack, busy, ref_err
    );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: shares the command unit between periodic
// auto-refresh, write bursts and read bursts, one operation at a time.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_INIT | SDRAM not initialised (or init_done dropped); timer held
// S_IDLE | no operation running; grant evaluated every cycle
// S_BUSY | operation in flight; waiting for cmd_done or timeout
module sdram_arbiter #(
    parameter int REF_PERIOD = 781,
    parameter int TIMEOUT    = 1023
) (
    input  logic            clk,
    input  logic            rst_n,
    sdram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    localparam logic [1:0]  CT_NONE  = 2'b00;
    localparam logic [1:0]  CT_REF   = 2'b01;
    localparam logic [1:0]  CT_WR    = 2'b10;
    localparam logic [1:0]  CT_RD    = 2'b11;
    localparam logic [11:0] REF_LAST = 12'(REF_PERIOD - 1);
    localparam logic [11:0] TO_LAST  = 12'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [11:0] ref_cnt_q;
    logic [11:0] to_cnt_q;
    logic        ref_pend_q;
    logic        ref_err_q;
    logic        last_rd_q;
    logic        cmd_start_q;
    logic        wr_ack_q;
    logic        rd_ack_q;
    logic        busy_q;
    logic [1:0]  cmd_type_q, cmd_type_d;

    logic [1:0]  grant;
    logic        rd_live;
    logic        ref_expire;
    logic        op_end;
    logic        op_timeout;

    assign rd_live    = bus.rd_req & bus.rd_valid;
    assign ref_expire = bus.init_done && (state_q != S_INIT) && (ref_cnt_q == REF_LAST);
    assign op_timeout = (state_q == S_BUSY) && !bus.cmd_done && (to_cnt_q == TO_LAST);
    assign op_end     = (state_q == S_BUSY) && (bus.cmd_done || (to_cnt_q == TO_LAST));

    // Grant selection; only meaningful in S_IDLE with the SDRAM initialised.
    always_comb begin
        grant = CT_NONE;
        if (state_q == S_IDLE && bus.init_done) begin
            if (ref_pend_q)
                grant = CT_REF;
            else if (bus.wr_req && rd_live)
                grant = last_rd_q ? CT_WR : CT_RD;
            else if (bus.wr_req)
                grant = CT_WR;
            else if (rd_live)
                grant = CT_RD;
        end
    end

    // Next-state and next command type; init_done low overrides everything.
    always_comb begin
        state_d    = state_q;
        cmd_type_d = CT_NONE;
        if (!bus.init_done) begin
            state_d = S_INIT;
        end else begin
            case (state_q)
                S_INIT: state_d = S_IDLE;
                S_IDLE: begin
                    cmd_type_d = grant;
                    if (grant != CT_NONE)
                        state_d = S_BUSY;
                end
                S_BUSY: begin
                    if (op_end)
                        state_d = S_IDLE;
                    else
                        cmd_type_d = cmd_type_q;
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_INIT;
        else
            state_q <= state_d;
    end

    // Refresh interval timer; frozen at zero until the arbiter leaves S_INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ref_cnt_q <= '0;
        else if (!bus.init_done || state_q == S_INIT || ref_expire)
            ref_cnt_q <= '0;
        else
            ref_cnt_q <= ref_cnt_q + 12'd1;
    end

    // Pending refresh flag; a new expiry beats a same-cycle refresh grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ref_pend_q <= 1'b0;
        else if (!bus.init_done)
            ref_pend_q <= 1'b0;
        else if (ref_expire)
            ref_pend_q <= 1'b1;
        else if (grant == CT_REF)
            ref_pend_q <= 1'b0;
    end

    // Sticky error: missed refresh slot or abandoned operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ref_err_q <= 1'b0;
        else if ((ref_expire && ref_pend_q && grant != CT_REF) ||
                 (op_timeout && bus.init_done))
            ref_err_q <= 1'b1;
    end

    // Operation watchdog: counts cycles spent in S_BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt_q <= '0;
        else if (state_q == S_BUSY && state_d == S_BUSY)
            to_cnt_q <= to_cnt_q + 12'd1;
        else
            to_cnt_q <= '0;
    end

    // Fairness memory; refresh grants leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_rd_q <= 1'b1;
        else if (grant == CT_WR)
            last_rd_q <= 1'b0;
        else if (grant == CT_RD)
            last_rd_q <= 1'b1;
    end

    // Registered outputs: launch pulses and held operation status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_start_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_type_q  <= CT_NONE;
        end else begin
            cmd_start_q <= (grant != CT_NONE);
            wr_ack_q    <= (grant == CT_WR);
            rd_ack_q    <= (grant == CT_RD);
            busy_q      <= (state_d == S_BUSY);
            cmd_type_q  <= cmd_type_d;
        end
    end

    assign bus.cmd_start = cmd_start_q;
    assign bus.cmd_type  = cmd_type_q;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.busy      = busy_q;
    assign bus.ref_err   = ref_err_q;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Schedules the shared SDRAM command unit between three requesters: periodic auto-refresh, the write-FIFO burst path and the read-FIFO burst path.
- Sits inside the SDRAM controller top, between the FIFO control logic (wr/rd burst requests) and the command/timing FSM.
- Issues one operation at a time and keeps refresh on schedule.
- Alternates write and read fairly when both are pending.

Parameters:
- REF_PERIOD, 781, clk cycles between refresh requests (7.81 us at 100 MHz); legal range 16..4095.
- TIMEOUT, 1023, max clk cycles in S_BUSY before the operation is abandoned; legal range 16..4095.

Ports:
- clk  in  1  controller clock (100 MHz); single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- init_done  in  1  SDRAM power-up sequence complete (level).
- wr_req  in  1  write FIFO holds at least one burst (level).
- rd_req  in  1  read FIFO has room for one burst (level).
- rd_valid  in  1  read path enable; rd_req is ignored while low.
- cmd_done  in  1  one-cycle pulse from the command unit when the current operation finishes.
- cmd_start  out  1  one-cycle pulse launching an operation.
- cmd_type  out  2  00 none, 01 refresh, 10 write, 11 read; held for the whole operation.
- wr_ack  out  1  one-cycle pulse, write burst granted.
- rd_ack  out  1  one-cycle pulse, read burst granted.
- busy  out  1  high from cmd_start until the cycle after cmd_done.
- ref_err  out  1  sticky: a refresh interval expired while the previous refresh was still pending, or an operation timed out.

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0; state S_INIT.
  - ref_cnt=0, ref_pend=0, to_cnt=0.
  - last_grant=READ, so the first contested grant goes to write.
- S_INIT:
  - ref_cnt is held at 0.
  - Moves to S_IDLE on the first cycle init_done=1.
- Refresh timer:
  - Runs only while init_done=1; increments every cycle.
  - At REF_PERIOD-1 it wraps to 0 and sets ref_pend.
  - If ref_pend is already 1 at expiry, ref_err is set to 1. ref_err clears only on reset.
  - Expiry in the same cycle as a refresh grant: the set wins, ref_pend stays 1, ref_err is not set.
- S_IDLE grant priority, evaluated combinationally each cycle:
  - 1) ref_pend → refresh.
  - 2) wr_req and (rd_req&rd_valid) → the opposite of last_grant.
  - 3) wr_req → write.
  - 4) rd_req&rd_valid → read.
  - 5) none → stay in S_IDLE.
- Issue timing:
  - On a grant, the next cycle enters S_BUSY with cmd_start=1, cmd_type set, busy=1, plus wr_ack or rd_ack for the matching grant.
  - Latency is 1 cycle from the request being sampled in S_IDLE to cmd_start.
  - The refresh grant clears ref_pend. A write or read grant updates last_grant; a refresh grant does not.
- S_BUSY:
  - cmd_type is held; to_cnt increments each cycle.
  - On cmd_done: next cycle S_IDLE, busy=0, cmd_type=00, to_cnt=0.
  - Back-to-back spacing: cmd_done at cycle t gives the earliest next cmd_start at t+2.
- Timeout: if to_cnt reaches TIMEOUT-1 without cmd_done, set ref_err and return to S_IDLE with the same output clearing as on cmd_done.
- Ignored inputs: cmd_done outside S_BUSY; rd_req while rd_valid=0.
- Requests are levels. A requester must drop its request by the cycle after its ack, or it is served again.
- init_done falling in any state:
  - Next cycle enters S_INIT.
  - cmd_type=00, busy=0; any pulse outputs are cancelled.
  - ref_pend=0, ref_cnt=0.
  - ref_err is kept.
- Invariants:
  - At most one of wr_ack/rd_ack is high in any cycle.
  - cmd_start is never high on two consecutive cycles.

Test Plan:
- Reset release, init_done rises at cycle 10, wr_req=1 from cycle 12 → cmd_start/wr_ack at cycle 13 with cmd_type=10; busy stays 1 until the cycle after cmd_done.
- wr_req and rd_req both held high, cmd_done 5 cycles after each cmd_start → grants alternate W,R,W,R; consecutive cmd_start pulses are 7 cycles apart.
- REF_PERIOD=16, wr_req high, refresh expires while a write is busy → after cmd_done the next grant is refresh (cmd_type=01), ahead of the pending write; ref_err stays 0.
- REF_PERIOD=16, cmd_done withheld for 40 cycles with TIMEOUT=64 → second expiry while ref_pend=1 sets ref_err=1, which persists until rst_n low.
- cmd_done never arrives, TIMEOUT=32 → ref_err=1 and the block returns to S_IDLE 32 cycles after cmd_start; a held rd_req (rd_valid=1) is granted 1 cycle later.
- init_done dropped mid-read → next cycle busy=0, cmd_type=00, state S_INIT; no ack while init_done=0; rd_req with rd_valid=0 never produces rd_ack.
